// File: rtl/ntp_time_select_if.sv
// AXI-lite register port of the NTP time selector: 5-bit byte address, 32-bit data.
// The master modport drives requests; the slave modport is the selector's view.
interface ntp_time_select_if;
  logic [4:0]  axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [4:0]  axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );
endinterface

// File: rtl/ntp_time_select.sv
// Picks one of NUM_CLOCKS NTP time sources, with a holdoff window before automatic failover.
// Selected time/strobe lag inputs by one cycle; AXI-lite accepts one write and one read at a time.
module ntp_time_select #(
  parameter int          NUM_CLOCKS     = 2,
  parameter int unsigned HOLDOFF_CYCLES = 1000
) (
  input  logic                     axi_aclk,
  input  logic                     reset,
  input  logic [NUM_CLOCKS*64-1:0] ntp_time,
  input  logic [NUM_CLOCKS-1:0]    ntp_time_upd,
  input  logic [NUM_CLOCKS-1:0]    sync_ok,
  output logic [63:0]              sel_time,
  output logic                     sel_time_upd,
  output logic [2:0]               sel_index,
  output logic                     sel_valid,
  output logic                     failover,
  ntp_time_select_if.slave         axi
);

  typedef enum logic [1:0] {ST_NOSRC, ST_LOCKED, ST_HOLDOFF, ST_MANUAL} state_e;

  state_e      state_q;
  logic [2:0]  sel_q;
  logic        sel_valid_q;
  logic        failover_q;
  logic [31:0] cnt_q;
  logic [31:0] fail_cnt_q;
  logic [63:0] sel_time_q;
  logic        sel_time_upd_q;
  logic        auto_en_q;
  logic [2:0]  pref_q;
  logic [31:0] holdoff_q;
  logic [31:0] snap_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Channels padded out to 8 so a 3-bit index can never fall off the end.
  logic [7:0]  sync8;
  logic [7:0]  upd8;
  logic [63:0] time8 [8];

  always_comb begin
    sync8 = '0;
    upd8  = '0;
    for (int i = 0; i < 8; i++) time8[i] = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sync8[i] = sync_ok[i];
      upd8[i]  = ntp_time_upd[i];
      time8[i] = ntp_time[64*i +: 64];
    end
  end

  logic [2:0] pref_eff;
  assign pref_eff = ({29'd0, pref_q} < NUM_CLOCKS) ? pref_q : 3'd0;

  // Result is {found, index}: preferred channel first, else the lowest healthy one.
  function automatic logic [3:0] pick(input logic [7:0] ok, input logic [2:0] pref,
                                      input logic excl_en, input logic [2:0] excl);
    logic [7:0] m;
    logic [3:0] r;
    m = ok;
    if (excl_en) m[excl] = 1'b0;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    if (m[pref]) r = {1'b1, pref};
    return r;
  endfunction

  logic [3:0] pick_any;
  logic [3:0] pick_alt;
  assign pick_any = pick(sync8, pref_eff, 1'b0, sel_q);
  assign pick_alt = pick(sync8, pref_eff, 1'b1, sel_q);

  logic [2:0] wsel;
  logic [2:0] rsel;
  logic       aw_hs;
  logic       ar_hs;
  logic       fail_clr;
  logic       fo_evt;

  assign wsel     = axi.axi_awaddr[4:2];
  assign rsel     = axi.axi_araddr[4:2];
  assign aw_hs    = axi.axi_awvalid & axi.axi_wvalid & ~bvalid_q & ~reset;
  assign ar_hs    = axi.axi_arvalid & ~rvalid_q & ~reset;
  assign fail_clr = aw_hs & (wsel == 3'd2);
  assign fo_evt   = auto_en_q & (state_q == ST_HOLDOFF) & ~sync8[sel_q] &
                    (cnt_q == 32'd0) & pick_alt[3];

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state_q     <= ST_NOSRC;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      failover_q  <= 1'b0;
      cnt_q       <= 32'd0;
      fail_cnt_q  <= 32'd0;
    end else begin
      failover_q <= 1'b0;
      // A clear landing on the same edge as a failover wins.
      if (fail_clr)
        fail_cnt_q <= 32'd0;
      else if (fo_evt && fail_cnt_q != 32'hFFFF_FFFF)
        fail_cnt_q <= fail_cnt_q + 32'd1;

      if (!auto_en_q) begin
        state_q     <= ST_MANUAL;
        sel_q       <= pref_eff;
        sel_valid_q <= sync8[pref_eff];
      end else begin
        case (state_q)
          ST_MANUAL: begin
            state_q     <= ST_NOSRC;
            sel_valid_q <= 1'b0;
          end
          ST_NOSRC: begin
            if (pick_any[3]) begin
              state_q     <= ST_LOCKED;
              sel_q       <= pick_any[2:0];
              sel_valid_q <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!sync8[sel_q]) begin
              state_q <= ST_HOLDOFF;
              cnt_q   <= holdoff_q;
            end
          end
          ST_HOLDOFF: begin
            if (sync8[sel_q]) begin
              state_q <= ST_LOCKED;
            end else if (cnt_q == 32'd0) begin
              if (pick_alt[3]) begin
                state_q    <= ST_LOCKED;
                sel_q      <= pick_alt[2:0];
                failover_q <= 1'b1;
              end else begin
                state_q     <= ST_NOSRC;
                sel_valid_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q - 32'd1;
            end
          end
          default: begin
            state_q     <= ST_NOSRC;
            sel_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      sel_time_q     <= 64'd0;
      sel_time_upd_q <= 1'b0;
    end else begin
      sel_time_q     <= time8[sel_q];
      sel_time_upd_q <= upd8[sel_q] & sel_valid_q;
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    case (rsel)
      3'd0:    rdata_d = {25'd0, pref_q, 3'd0, auto_en_q};
      3'd1:    rdata_d = {16'd0, sync8, 4'd0, sel_valid_q, sel_q};
      3'd2:    rdata_d = fail_cnt_q;
      3'd3:    rdata_d = holdoff_q;
      3'd4:    rdata_d = sel_time_q[63:32];
      3'd5:    rdata_d = snap_q;
      default: rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      auto_en_q <= 1'b1;
      pref_q    <= 3'd0;
      holdoff_q <= 32'(HOLDOFF_CYCLES);
      snap_q    <= 32'd0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      if (aw_hs) begin
        bvalid_q <= 1'b1;
        if (wsel == 3'd0) begin
          auto_en_q <= axi.axi_wdata[0];
          pref_q    <= axi.axi_wdata[6:4];
        end else if (wsel == 3'd3) begin
          holdoff_q <= axi.axi_wdata;
        end
      end else if (bvalid_q && axi.axi_bready) begin
        bvalid_q <= 1'b0;
      end

      // TIME_HI read freezes the low word so a later TIME_LO read is coherent.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        if (rsel == 3'd4) snap_q <= sel_time_q[31:0];
      end else if (rvalid_q && axi.axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign axi.axi_awready = aw_hs;
  assign axi.axi_wready  = aw_hs;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bresp   = 2'b00;
  assign axi.axi_arready = ar_hs;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rdata   = rdata_q;
  assign axi.axi_rresp   = 2'b00;

  assign sel_time     = sel_time_q;
  assign sel_time_upd = sel_time_upd_q;
  assign sel_index    = sel_q;
  assign sel_valid    = sel_valid_q;
  assign failover     = failover_q;

  logic unused_axi;
  assign unused_axi = ^{axi.axi_wstrb, axi.axi_awaddr[1:0], axi.axi_araddr[1:0]};

endmodule

// File: tb/tb_ntp_time_select.sv
// Bench for ntp_time_select: directed scenarios then random traffic, all cycles
// compared against a behavioural source-selection and register model.
module tb_ntp_time_select;
  localparam int          NC = 4;
  localparam int unsigned HO = 1000;

  localparam int MD_NOSRC  = 0;
  localparam int MD_LOCK   = 1;
  localparam int MD_HOLD   = 2;
  localparam int MD_MANUAL = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC*64-1:0] ntp_time;
  logic [NC-1:0]    ntp_upd;
  logic [NC-1:0]    sync;
  logic [63:0]      sel_time;
  logic             sel_time_upd;
  logic [2:0]       sel_index;
  logic             sel_valid;
  logic             failover;

  ntp_time_select_if axi_if();

  ntp_time_select #(.NUM_CLOCKS(NC), .HOLDOFF_CYCLES(HO)) dut (
    .axi_aclk    (clk),
    .reset       (rst),
    .ntp_time    (ntp_time),
    .ntp_time_upd(ntp_upd),
    .sync_ok     (sync),
    .sel_time    (sel_time),
    .sel_time_upd(sel_time_upd),
    .sel_index   (sel_index),
    .sel_valid   (sel_valid),
    .failover    (failover),
    .axi         (axi_if.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_mode;
  logic [2:0]  m_sel;
  logic        m_valid, m_fo, m_upd, m_auto, m_bvalid, m_rvalid;
  logic [2:0]  m_pref;
  logic [31:0] m_cnt, m_fail, m_hold, m_snap, m_rdata;
  logic [63:0] m_time;

  logic        g_rand = 1'b0;
  logic        g_aw, g_ar, g_b, g_r;
  logic [31:0] g_rdata;

  function automatic int pick(input logic [NC-1:0] ok, input int pref, input int excl);
    if (pref != excl && ok[pref]) return pref;
    for (int i = 0; i < NC; i++) if (i != excl && ok[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] reg_val(input logic [2:0] idx, input logic [NC-1:0] s);
    case (idx)
      3'd0:    return {25'd0, m_pref, 3'd0, m_auto};
      3'd1:    return 32'(s) * 256 + 32'(m_valid) * 8 + 32'(m_sel);
      3'd2:    return m_fail;
      3'd3:    return m_hold;
      3'd4:    return m_time[63:32];
      3'd5:    return m_snap;
      default: return 32'd0;
    endcase
  endfunction

  task automatic rand_inputs();
    if ($urandom_range(9) == 0) sync = NC'($urandom_range(15));
    for (int i = 0; i < NC; i++) ntp_time[64*i +: 64] = {$urandom, $urandom};
    ntp_upd = NC'($urandom_range(15));
  endtask

  task automatic step();
    logic            r, aw, ar, br, rr, o_valid, inc;
    logic [NC-1:0]   s, u;
    logic [NC*64-1:0] t;
    logic [2:0]      wa, ra, o_sel;
    logic [31:0]     wd, rd;
    logic [63:0]     o_time;
    int              pe, p;
    if (g_rand) rand_inputs();
    #1;
    r  = rst;
    s  = sync;
    u  = ntp_upd;
    t  = ntp_time;
    wa = axi_if.axi_awaddr[4:2];
    wd = axi_if.axi_wdata;
    ra = axi_if.axi_araddr[4:2];
    br = axi_if.axi_bready;
    rr = axi_if.axi_rready;
    aw = axi_if.axi_awvalid && axi_if.axi_wvalid && !m_bvalid && !r;
    ar = axi_if.axi_arvalid && !m_rvalid && !r;
    check("awready", axi_if.axi_awready, aw);
    check("wready", axi_if.axi_wready, aw);
    check("arready", axi_if.axi_arready, ar);
    if (m_rvalid) check("rdata", axi_if.axi_rdata, m_rdata);
    g_aw = axi_if.axi_awready;
    g_ar = axi_if.axi_arready;
    g_b  = axi_if.axi_bvalid && br;
    g_r  = axi_if.axi_rvalid && rr;
    if (g_r) g_rdata = axi_if.axi_rdata;
    rd = reg_val(ra, s);
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = MD_NOSRC; m_sel = 3'd0; m_valid = 1'b0; m_fo = 1'b0; m_cnt = 0;
      m_time = 64'd0; m_upd = 1'b0; m_fail = 0; m_auto = 1'b1; m_pref = 3'd0;
      m_hold = HO; m_bvalid = 1'b0; m_rvalid = 1'b0; m_rdata = 0; m_snap = 0;
    end else begin
      o_sel = m_sel; o_valid = m_valid; o_time = m_time;
      pe = (int'(m_pref) < NC) ? int'(m_pref) : 0;
      inc = 1'b0;
      m_fo = 1'b0;
      if (!m_auto) begin
        m_mode = MD_MANUAL; m_sel = 3'(pe); m_valid = s[pe];
      end else if (m_mode == MD_MANUAL) begin
        m_mode = MD_NOSRC; m_valid = 1'b0;
      end else if (m_mode == MD_NOSRC) begin
        if (s != 0) begin
          m_sel = 3'(pick(s, pe, -1)); m_mode = MD_LOCK; m_valid = 1'b1;
        end
      end else if (m_mode == MD_LOCK) begin
        if (!s[m_sel]) begin m_mode = MD_HOLD; m_cnt = m_hold; end
      end else begin
        if (s[m_sel]) m_mode = MD_LOCK;
        else if (m_cnt == 0) begin
          p = pick(s, pe, int'(m_sel));
          if (p >= 0) begin
            m_sel = 3'(p); m_mode = MD_LOCK; m_fo = 1'b1; inc = 1'b1;
          end else begin
            m_mode = MD_NOSRC; m_valid = 1'b0;
          end
        end else m_cnt = m_cnt - 1;
      end
      m_time = t[64*o_sel +: 64];
      m_upd  = u[o_sel] && o_valid;
      if (aw && wa == 3'd2) m_fail = 0;
      else if (inc && m_fail != 32'hFFFF_FFFF) m_fail = m_fail + 1;
      if (ar) begin
        m_rvalid = 1'b1; m_rdata = rd;
        if (ra == 3'd4) m_snap = o_time[31:0];
      end else if (m_rvalid && rr) m_rvalid = 1'b0;
      if (aw) begin
        m_bvalid = 1'b1;
        if (wa == 3'd0) begin m_auto = wd[0]; m_pref = wd[6:4]; end
        else if (wa == 3'd3) m_hold = wd;
      end else if (m_bvalid && br) m_bvalid = 1'b0;
    end
    check("sel_index", sel_index, m_sel);
    check("sel_valid", sel_valid, m_valid);
    check("failover", failover, m_fo);
    check("sel_time", sel_time, m_time);
    check("sel_time_upd", sel_time_upd, m_upd);
    check("bvalid", axi_if.axi_bvalid, m_bvalid);
    check("rvalid", axi_if.axi_rvalid, m_rvalid);
    check("resp", {axi_if.axi_bresp, axi_if.axi_rresp}, 4'd0);
  endtask

  task automatic axi_write(input logic [2:0] idx, input logic [31:0] data);
    axi_if.axi_awaddr  = {idx, 2'($urandom_range(3))};
    axi_if.axi_wdata   = data;
    axi_if.axi_wstrb   = 4'($urandom_range(15));
    axi_if.axi_awvalid = 1'b1;
    axi_if.axi_wvalid  = 1'b1;
    for (int n = 0; n < 32; n++) begin step(); if (g_aw) break; end
    check("aw_timeout", g_aw, 1'b1);
    axi_if.axi_awvalid = 1'b0;
    axi_if.axi_wvalid  = 1'b0;
    if (g_rand) repeat ($urandom_range(3)) step();
    axi_if.axi_bready = 1'b1;
    for (int n = 0; n < 32; n++) begin step(); if (g_b) break; end
    check("b_timeout", g_b, 1'b1);
    axi_if.axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [2:0] idx, output logic [31:0] data);
    axi_if.axi_araddr  = {idx, 2'($urandom_range(3))};
    axi_if.axi_arvalid = 1'b1;
    for (int n = 0; n < 32; n++) begin step(); if (g_ar) break; end
    check("ar_timeout", g_ar, 1'b1);
    axi_if.axi_arvalid = 1'b0;
    if (g_rand) repeat ($urandom_range(2)) step();
    axi_if.axi_rready = 1'b1;
    for (int n = 0; n < 32; n++) begin step(); if (g_r) break; end
    check("r_timeout", g_r, 1'b1);
    axi_if.axi_rready = 1'b0;
    data = g_rdata;
  endtask

  task automatic do_reset();
    axi_if.axi_awvalid = 1'b0; axi_if.axi_wvalid = 1'b0; axi_if.axi_bready = 1'b0;
    axi_if.axi_arvalid = 1'b0; axi_if.axi_rready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    axi_if.axi_awaddr = '0; axi_if.axi_wdata = '0; axi_if.axi_wstrb = '0;
    axi_if.axi_araddr = '0;
    sync = '0; ntp_upd = '0;
    for (int i = 0; i < NC; i++) ntp_time[64*i +: 64] = 64'h0101_0101_0000_0000 * (i + 1);
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    do_reset();

    check("rst_sel_index", sel_index, 3'd0);
    check("rst_sel_valid", sel_valid, 1'b0);
    check("rst_sel_time", sel_time, 64'd0);
    check("rst_failover", failover, 1'b0);
    axi_read(3'd0, rd); check("rst_ctrl", rd, 32'h1);
    axi_read(3'd3, rd); check("rst_holdoff", rd, 32'd1000);
    axi_read(3'd2, rd); check("rst_fail_cnt", rd, 32'd0);

    // Lock onto the only healthy channel, then stay there when ch0 returns
    sync = 4'b0010;
    step();
    check("lock_idx", sel_index, 3'd1);
    check("lock_valid", sel_valid, 1'b1);
    check("lock_fo", failover, 1'b0);
    sync = 4'b0011;
    repeat (5) step();
    check("stay_idx", sel_index, 3'd1);

    // Holdoff of 4 expires: failover pulse on the sixth edge after ch0 drops
    do_reset();
    sync = 4'b0011;
    axi_write(3'd3, 32'd4);
    check("pre_fo_idx", sel_index, 3'd0);
    sync = 4'b0010;
    for (int i = 0; i < 5; i++) begin step(); check("fo_early", failover, 1'b0); end
    step();
    check("fo_pulse", failover, 1'b1);
    check("fo_idx", sel_index, 3'd1);
    step();
    check("fo_once", failover, 1'b0);
    axi_read(3'd2, rd); check("fo_count", rd, 32'd1);

    // Short dropout inside the holdoff window recovers without failover
    do_reset();
    sync = 4'b0011;
    axi_write(3'd3, 32'd10);
    sync = 4'b0010;
    repeat (3) step();
    sync = 4'b0011;
    for (int i = 0; i < 15; i++) begin step(); check("rec_no_fo", failover, 1'b0); end
    check("rec_idx", sel_index, 3'd0);
    axi_read(3'd2, rd); check("rec_count", rd, 32'd0);

    // Manual mode follows pref_idx
    sync = 4'b0100;
    axi_write(3'd0, 32'h20);
    repeat (2) step();
    check("man_idx", sel_index, 3'd2);
    check("man_valid", sel_valid, 1'b1);
    axi_read(3'd1, rd); check("man_status", rd, 32'h0000_040A);
    sync = 4'b0000;
    repeat (2) step();
    check("man_invalid", sel_valid, 1'b0);

    // Coherent 64-bit time read across a time change
    axi_write(3'd0, 32'h1);
    sync = 4'b0001;
    ntp_time[63:0] = 64'h1122_3344_5566_7788;
    repeat (4) step();
    axi_read(3'd4, rd); check("time_hi", rd, 32'h1122_3344);
    ntp_time[63:0] = 64'hAABB_CCDD_EEFF_0011;
    repeat (3) step();
    axi_read(3'd5, rd); check("time_lo", rd, 32'h5566_7788);

    // bvalid held while bready low; the next write waits for it
    axi_if.axi_awaddr = 5'h0C; axi_if.axi_wdata = 32'd7;
    axi_if.axi_awvalid = 1'b1; axi_if.axi_wvalid = 1'b1; axi_if.axi_bready = 1'b0;
    for (int n = 0; n < 32; n++) begin step(); if (g_aw) break; end
    check("bp_first_aw", g_aw, 1'b1);
    axi_if.axi_wdata = 32'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_bvalid", axi_if.axi_bvalid, 1'b1);
      check("bp_stall", axi_if.axi_awready, 1'b0);
    end
    axi_if.axi_bready = 1'b1;
    step();
    check("bp_release", g_aw, 1'b0);
    step();
    check("bp_second_aw", g_aw, 1'b1);
    axi_if.axi_awvalid = 1'b0; axi_if.axi_wvalid = 1'b0;
    step();
    axi_if.axi_bready = 1'b0;
    axi_read(3'd3, rd); check("bp_holdoff", rd, 32'd3);

    // Random traffic against the model
    do_reset();
    g_rand = 1'b1;
    for (int it = 0; it < 2500; it++) begin
      case ($urandom_range(19))
        0, 1: begin
          rd = $urandom;
          rd[0] = ($urandom_range(5) != 0);
          axi_write(3'd0, rd);
        end
        2: axi_write(3'd3, 32'($urandom_range(8)));
        3: axi_write(3'd2, $urandom);
        4: axi_write(3'($urandom_range(4, 7)) & 3'd7, $urandom);
        5: axi_write(3'd1, $urandom);
        6, 7: axi_read(3'($urandom_range(7)), rd);
        8: begin
          if ($urandom_range(9) == 0) begin
            axi_if.axi_awaddr = 5'($urandom_range(31));
            axi_if.axi_wdata = $urandom;
            axi_if.axi_araddr = 5'($urandom_range(31));
            axi_if.axi_awvalid = 1'b1; axi_if.axi_wvalid = 1'b1; axi_if.axi_arvalid = 1'b1;
            step();
            rst = 1'b1;
            axi_if.axi_awvalid = 1'b0; axi_if.axi_wvalid = 1'b0; axi_if.axi_arvalid = 1'b0;
            step();
            rst = 1'b0;
            step();
          end else step();
        end
        default: step();
      endcase
    end
    g_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
